// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one adder among NUM_REQ requesters; grant 1 cycle after request,
// done ADD_LATENCY+1 cycles after grant; requests are held off (no grant) while an operation is in flight.
module adder_share_arbiter #(
    parameter int WIDTH       = 32,
    parameter int NUM_REQ     = 4,
    parameter int ADD_LATENCY = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   a_in,
    input  logic [NUM_REQ*WIDTH-1:0]   b_in,
    input  logic [NUM_REQ-1:0]         cin_in,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         done,
    output logic [WIDTH-1:0]           result,
    output logic                       result_carry,
    output logic                       busy,
    output logic [WIDTH-1:0]           add_a,
    output logic [WIDTH-1:0]           add_b,
    output logic                       add_cin,
    input  logic [WIDTH-1:0]           add_sum,
    input  logic                       add_carry
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [2:0] LAT = 3'(ADD_LATENCY);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_rr;
    logic [IDX_W-1:0] r_owner;
    logic [2:0]       r_cnt;

    logic             w_any;
    logic [IDX_W-1:0] w_sel;
    logic [IDX_W:0]   w_idx;

    // Scan downward so the candidate closest to the pointer is the last one written and wins.
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        w_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = {1'b0, r_rr} + (IDX_W+1)'(k);
            if (w_idx >= (IDX_W+1)'(NUM_REQ)) begin
                w_idx = w_idx - (IDX_W+1)'(NUM_REQ);
            end
            if (req[w_idx[IDX_W-1:0]]) begin
                w_any = 1'b1;
                w_sel = w_idx[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_rr         <= '0;
            r_owner      <= '0;
            r_cnt        <= '0;
            grant        <= '0;
            done         <= '0;
            result       <= '0;
            result_carry <= 1'b0;
            busy         <= 1'b0;
            add_a        <= '0;
            add_b        <= '0;
            add_cin      <= 1'b0;
        end else begin
            grant <= '0;
            done  <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        add_a   <= a_in[w_sel*WIDTH +: WIDTH];
                        add_b   <= b_in[w_sel*WIDTH +: WIDTH];
                        add_cin <= cin_in[w_sel];
                        r_owner <= w_sel;
                        grant   <= NUM_REQ'(1) << w_sel;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_cnt <= r_cnt + 3'd1;
                    // Adder output is valid LAT edges after operands settle.
                    if (r_cnt == LAT) begin
                        result       <= add_sum;
                        result_carry <= add_carry;
                        done         <= NUM_REQ'(1) << r_owner;
                        r_state      <= DONE;
                    end
                end
                DONE: begin
                    r_rr    <= (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + IDX_W'(1);
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter: one ADD_LATENCY=1 and one ADD_LATENCY=0 instance
// on shared stimulus, each with its own behavioural adder.
module tb_adder_share_arbiter;

    logic         clock = 1'b0;
    logic         reset;
    logic [3:0]   req;
    logic [127:0] a_in, b_in;
    logic [3:0]   cin_in;
    logic         use_z;

    logic [3:0]  grant1, done1, grant0, done0;
    logic [31:0] result1, result0, add_a1, add_a0, add_b1, add_b0;
    logic        carry1, carry0, busy1, busy0, add_cin1, add_cin0;
    logic [31:0] sum1, sum0;
    logic        sc1, sc0;

    logic [3:0]  m_grant, m_done;
    logic [31:0] m_result, m_add_a, m_add_b;
    logic        m_carry, m_busy, m_add_cin;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    adder_share_arbiter #(.WIDTH(32), .NUM_REQ(4), .ADD_LATENCY(1)) dut1 (
        .clock(clock), .reset(reset), .req(req), .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
        .grant(grant1), .done(done1), .result(result1), .result_carry(carry1), .busy(busy1),
        .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1), .add_sum(sum1), .add_carry(sc1)
    );

    adder_share_arbiter #(.WIDTH(32), .NUM_REQ(4), .ADD_LATENCY(0)) dut0 (
        .clock(clock), .reset(reset), .req(req), .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
        .grant(grant0), .done(done0), .result(result0), .result_carry(carry0), .busy(busy0),
        .add_a(add_a0), .add_b(add_b0), .add_cin(add_cin0), .add_sum(sum0), .add_carry(sc0)
    );

    always_ff @(posedge clock) begin
        {sc1, sum1} <= {1'b0, add_a1} + {1'b0, add_b1} + {32'd0, add_cin1};
    end
    assign {sc0, sum0} = {1'b0, add_a0} + {1'b0, add_b0} + {32'd0, add_cin0};

    assign m_grant   = use_z ? grant0   : grant1;
    assign m_done    = use_z ? done0    : done1;
    assign m_result  = use_z ? result0  : result1;
    assign m_carry   = use_z ? carry0   : carry1;
    assign m_busy    = use_z ? busy0    : busy1;
    assign m_add_a   = use_z ? add_a0   : add_a1;
    assign m_add_b   = use_z ? add_b0   : add_b1;
    assign m_add_cin = use_z ? add_cin0 : add_cin1;

    // Issues one request, drops it when granted, then scrambles the operands and waits for done.
    task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b, input logic c,
                          output int glat, output logic [3:0] gvec, output int dlat,
                          output logic [3:0] dvec, output logic [31:0] res, output logic rc,
                          output logic busy_ok, output logic idle_ok);
        glat = -1; dlat = -1; gvec = '0; dvec = '0; res = '0; rc = 1'b0;
        busy_ok = 1'b1; idle_ok = 1'b0;
        a_in[idx*32 +: 32] = a;
        b_in[idx*32 +: 32] = b;
        cin_in[idx] = c;
        req[idx] = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (m_grant != 4'd0) begin
                glat = i;
                gvec = m_grant;
                break;
            end
        end
        req[idx] = 1'b0;
        if (glat < 0) return;
        if (!m_busy) busy_ok = 1'b0;
        a_in[idx*32 +: 32] = ~a;
        b_in[idx*32 +: 32] = ~b;
        cin_in[idx] = ~c;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (!m_busy) busy_ok = 1'b0;
            if (m_done != 4'd0) begin
                dlat = i;
                dvec = m_done;
                res  = m_result;
                rc   = m_carry;
                break;
            end
        end
        @(negedge clock);
        idle_ok = !m_busy && (m_grant == 4'd0) && (m_done == 4'd0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        n_vec++; if ({m_grant, m_done} !== 8'd0) begin n_err++; $display("FAIL reset_grant_done got %h want 00", {m_grant, m_done}); end
        n_vec++; if ({m_carry, m_result} !== 33'd0) begin n_err++; $display("FAIL reset_result got %h want 0", {m_carry, m_result}); end
        n_vec++; if ({m_add_cin, m_add_a, m_add_b} !== 65'd0) begin n_err++; $display("FAIL reset_operands got %h want 0", {m_add_cin, m_add_a, m_add_b}); end
        n_vec++; if (m_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", m_busy); end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_single();
        int glat, dlat; logic [3:0] gvec, dvec; logic [31:0] res; logic rc, bok, iok;
        run_op(0, 32'd500, 32'd600, 1'b0, glat, gvec, dlat, dvec, res, rc, bok, iok);
        n_vec++; if (glat !== 1) begin n_err++; $display("FAIL single_grant_lat got %0d want 1", glat); end
        n_vec++; if (gvec !== 4'b0001) begin n_err++; $display("FAIL single_grant got %b want 0001", gvec); end
        n_vec++; if (dlat !== 2) begin n_err++; $display("FAIL single_done_lat got %0d want 2", dlat); end
        n_vec++; if (dvec !== 4'b0001) begin n_err++; $display("FAIL single_done got %b want 0001", dvec); end
        n_vec++; if ({rc, res} !== {1'b0, 32'd1100}) begin n_err++; $display("FAIL single_result got %0d/%0d want 0/1100", rc, res); end
        n_vec++; if (bok !== 1'b1) begin n_err++; $display("FAIL single_busy got %b want 1", bok); end
        n_vec++; if (iok !== 1'b1) begin n_err++; $display("FAIL single_idle_after got %b want 1", iok); end
    endtask

    task automatic test_carry_in();
        int glat, dlat; logic [3:0] gvec, dvec; logic [31:0] res; logic rc, bok, iok;
        run_op(2, 32'd1500, 32'd11600, 1'b1, glat, gvec, dlat, dvec, res, rc, bok, iok);
        n_vec++; if (dvec !== 4'b0100) begin n_err++; $display("FAIL cin_done2 got %b want 0100", dvec); end
        n_vec++; if ({rc, res} !== {1'b0, 32'd13101}) begin n_err++; $display("FAIL cin_result2 got %0d/%0d want 0/13101", rc, res); end
        run_op(1, 32'd50000, 32'd60020, 1'b0, glat, gvec, dlat, dvec, res, rc, bok, iok);
        n_vec++; if (dvec !== 4'b0010) begin n_err++; $display("FAIL cin_done1 got %b want 0010", dvec); end
        n_vec++; if ({rc, res} !== {1'b0, 32'd110020}) begin n_err++; $display("FAIL cin_result1 got %0d/%0d want 0/110020", rc, res); end
    endtask

    task automatic test_wrap();
        int glat, dlat; logic [3:0] gvec, dvec; logic [31:0] res; logic rc, bok, iok;
        run_op(3, 32'hFFFFFFFF, 32'd1, 1'b0, glat, gvec, dlat, dvec, res, rc, bok, iok);
        n_vec++; if (dvec !== 4'b1000) begin n_err++; $display("FAIL wrap_done got %b want 1000", dvec); end
        n_vec++; if ({rc, res} !== {1'b1, 32'd0}) begin n_err++; $display("FAIL wrap_result got %0d/%0d want 1/0", rc, res); end
        run_op(3, 32'hFFFFFFFF, 32'd1, 1'b1, glat, gvec, dlat, dvec, res, rc, bok, iok);
        n_vec++; if ({rc, res} !== {1'b1, 32'd1}) begin n_err++; $display("FAIL wrap_cin_result got %0d/%0d want 1/1", rc, res); end
        n_vec++; if ({m_add_cin, m_add_a, m_add_b} !== {1'b1, 32'hFFFFFFFF, 32'd1}) begin
            n_err++; $display("FAIL wrap_operands_held got %h want 1ffffffff00000001", {m_add_cin, m_add_a, m_add_b});
        end
        n_vec++; if ({m_carry, m_result} !== {1'b1, 32'd1}) begin n_err++; $display("FAIL wrap_result_held got %h want 100000001", {m_carry, m_result}); end
    endtask

    task automatic test_round_robin();
        int order[8];
        int gcyc[8];
        int exp_order[8] = '{0, 1, 2, 3, 0, 3, 0, 3};
        int n = 0;
        int gi;
        int bad_inv = 0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_in[i*32 +: 32] = 32'(i * 10);
            b_in[i*32 +: 32] = 32'd1;
        end
        cin_in = 4'd0;
        req = 4'hF;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clock);
            if ($countones(m_grant) > 1 || $countones(m_done) > 1 || (m_grant != 0 && m_done != 0)) bad_inv++;
            if (m_grant != 4'd0) begin
                gi = 0;
                for (int k = 0; k < 4; k++) if (m_grant[k]) gi = k;
                order[n] = gi;
                gcyc[n] = cyc;
                n++;
                if (n == 4) req = 4'b1001;
                if (n == 8) break;
            end
        end
        req = 4'd0;
        n_vec++; if (n !== 8) begin n_err++; $display("FAIL rr_grant_count got %0d want 8", n); end
        for (int i = 0; i < n; i++) begin
            n_vec++; if (order[i] !== exp_order[i]) begin n_err++; $display("FAIL rr_order[%0d] got %0d want %0d", i, order[i], exp_order[i]); end
        end
        for (int i = 1; i < n; i++) begin
            n_vec++; if (gcyc[i] - gcyc[i-1] !== 4) begin n_err++; $display("FAIL rr_spacing[%0d] got %0d want 4", i, gcyc[i] - gcyc[i-1]); end
        end
        n_vec++; if (bad_inv !== 0) begin n_err++; $display("FAIL rr_onehot_invariant got %0d bad cycles want 0", bad_inv); end
        repeat (6) @(negedge clock);
    endtask

    task automatic test_reset_exec();
        int glat, dlat; logic [3:0] gvec, dvec; logic [31:0] res; logic rc, bok, iok;
        int got_g = 0;
        int stray = 0;
        a_in[32 +: 32] = 32'd3;
        b_in[32 +: 32] = 32'd4;
        cin_in[1] = 1'b0;
        req[1] = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (m_grant == 4'b0010) begin got_g = 1; break; end
        end
        req[1] = 1'b0;
        n_vec++; if (got_g !== 1) begin n_err++; $display("FAIL rst_exec_grant got %0d want 1", got_g); end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        n_vec++; if ({m_grant, m_done, m_busy} !== 9'd0) begin n_err++; $display("FAIL rst_exec_ctrl got %h want 0", {m_grant, m_done, m_busy}); end
        n_vec++; if ({m_carry, m_result, m_add_cin, m_add_a, m_add_b} !== 98'd0) begin
            n_err++; $display("FAIL rst_exec_data got %h want 0", {m_carry, m_result, m_add_cin, m_add_a, m_add_b});
        end
        repeat (8) begin
            @(negedge clock);
            if (m_done != 4'd0 || m_grant != 4'd0) stray++;
        end
        n_vec++; if (stray !== 0) begin n_err++; $display("FAIL rst_exec_no_done got %0d pulses want 0", stray); end
        run_op(1, 32'd7, 32'd8, 1'b0, glat, gvec, dlat, dvec, res, rc, bok, iok);
        n_vec++; if (dvec !== 4'b0010) begin n_err++; $display("FAIL rst_exec_retry_done got %b want 0010", dvec); end
        n_vec++; if ({rc, res} !== {1'b0, 32'd15}) begin n_err++; $display("FAIL rst_exec_retry_result got %0d/%0d want 0/15", rc, res); end
    endtask

    task automatic test_latency0();
        int glat, dlat; logic [3:0] gvec, dvec; logic [31:0] res; logic rc, bok, iok;
        int got_g = 0;
        int stray = 0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        use_z = 1'b1;
        run_op(0, 32'd10, 32'd20, 1'b1, glat, gvec, dlat, dvec, res, rc, bok, iok);
        n_vec++; if (glat !== 1) begin n_err++; $display("FAIL lat0_grant_lat got %0d want 1", glat); end
        n_vec++; if (dlat !== 1) begin n_err++; $display("FAIL lat0_done_lat got %0d want 1", dlat); end
        n_vec++; if (dvec !== 4'b0001) begin n_err++; $display("FAIL lat0_done got %b want 0001", dvec); end
        n_vec++; if ({rc, res} !== {1'b0, 32'd31}) begin n_err++; $display("FAIL lat0_result got %0d/%0d want 0/31", rc, res); end
        a_in[0 +: 32] = 32'd1;
        b_in[0 +: 32] = 32'd2;
        cin_in[0] = 1'b0;
        req[0] = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (m_grant == 4'b0001) begin got_g = 1; break; end
        end
        n_vec++; if (got_g !== 1) begin n_err++; $display("FAIL lat0_second_grant got %0d want 1", got_g); end
        req = 4'b0100;
        @(negedge clock);
        n_vec++; if (m_done !== 4'b0001) begin n_err++; $display("FAIL lat0_second_done got %b want 0001", m_done); end
        n_vec++; if (m_result !== 32'd3) begin n_err++; $display("FAIL lat0_second_result got %0d want 3", m_result); end
        req = 4'd0;
        repeat (8) begin
            @(negedge clock);
            if (m_grant != 4'd0 || m_done != 4'd0) stray++;
        end
        n_vec++; if (stray !== 0) begin n_err++; $display("FAIL lat0_withdrawn_req got %0d pulses want 0", stray); end
    endtask

    initial begin
        reset  = 1'b1;
        req    = 4'd0;
        a_in   = '0;
        b_in   = '0;
        cin_in = 4'd0;
        use_z  = 1'b0;
        test_reset();
        test_single();
        test_carry_in();
        test_wrap();
        test_round_robin();
        test_reset_exec();
        test_latency0();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
